// File: rtl/bit_subtractor.sv
// Purpose: bit-serial unsigned subtractor, diff = A - B, one bit per clock, LSB first.
// Latency: WIDTH cycles from the accepting edge to done; a new operation may start every WIDTH+1 cycles.
// Backpressure: none; load is only honoured in IDLE or DONE and is silently ignored while busy.
module bit_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  // Counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits never wrap.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operand shift registers, partial difference, borrow loop and bit counter.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] part;
  logic             bor_ff;
  logic [CW-1:0]    cnt;

  // Combinational helpers.
  logic             accept;
  logic             last;
  logic             a0;
  logic             b0;
  logic             d;
  logic             bout;
  logic [WIDTH-1:0] part_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // A start request is only taken when no operation is in flight.
  assign accept = load && ((state == IDLE) || (state == DONE));

  // The edge that processes the MSB also retires the operation.
  assign last = (state == SHIFT) && (cnt == LAST_BIT);

  // One-bit full subtractor fed by the operand LSBs and the borrow loop.
  always_comb begin
    a0       = a_sr[0];
    b0       = b_sr[0];
    d        = a0 ^ b0 ^ bor_ff;
    bout     = (~a0 & b0) | (~(a0 ^ b0) & bor_ff);
    part_nxt = {d, part[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: DONE is only left through a new load, SHIFT only by finishing.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_BIT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (load) begin
          state_nxt = SHIFT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state, so busy/done come straight off flops.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      SHIFT:   busy_nxt = 1'b1;
      DONE:    done_nxt = 1'b1;
      default: begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
      end
    endcase
  end

  // Registered status flags; they track the state register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Serial datapath: capture on accept, shift one bit per edge while in SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      part   <= '0;
      bor_ff <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= A;
      b_sr   <= B;
      part   <= '0;
      bor_ff <= 1'b0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      part   <= part_nxt;
      bor_ff <= bout;
      // Hold at the last bit value rather than wrapping back to zero.
      if (cnt != LAST_BIT) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Result register: only the retiring edge updates it; SHIFT keeps the old result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else if (last) begin
      diff   <= part_nxt;
      borrow <= bout;
      zero   <= (part_nxt == '0);
    end
  end

endmodule
